rsa_modexp_ctrl: RTL and testbench

- Modular-exponentiation sequencer directly upstream of the 1024-bit Montgomery multiplier.
- Computes result = X^E mod M by left-to-right square-and-multiply in the Montgomery domain, issuing one multiplication at a time.
- Owns the multiplier's start/operand side and consumes its result/done side.
- The multiplier stays outside this block; the RSA top level wires the mont_* ports to it. This lets the bench substitute a behavioural model.

---
 rtl/rsa_pkg.sv | 24 ++
 rtl/rsa_modexp_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation datapath: default
// widths and the sequencer state encoding (also decoded by the top-level
// debug mux).
package rsa_pkg;

  localparam int N_DEF     = 1024;
  localparam int E_W_DEF   = 1024;
  localparam int LEN_W_DEF = 11;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    TO_MONT   = 4'd1,
    WAIT_TO   = 4'd2,
    SQ        = 4'd3,
    WAIT_SQ   = 4'd4,
    MUL       = 4'd5,
    WAIT_MUL  = 4'd6,
    NEXT      = 4'd7,
    FROM      = 4'd8,
    WAIT_FROM = 4'd9,
    DONE      = 4'd10
  } state_t;

endpackage

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer in the Montgomery domain.
// Drives one Montgomery product at a time on the mont_* side and folds the
// returned products into the accumulator until X^E mod M is available.
module rsa_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int E_W   = E_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     in_x,
  input  logic [E_W-1:0]   in_e,
  input  logic [LEN_W-1:0] in_e_len,
  input  logic [N-1:0]     in_m,
  input  logic [N-1:0]     in_r_mod_m,
  input  logic [N-1:0]     in_r2_mod_m,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     result,
  output logic             mont_start,
  output logic [N-1:0]     mont_a,
  output logic [N-1:0]     mont_b,
  output logic [N-1:0]     mont_m,
  input  logic [N-1:0]     mont_result,
  input  logic             mont_done
);

  localparam int               KW   = (E_W > 1) ? $clog2(E_W) : 1;
  localparam logic [LEN_W-1:0] EW_L = LEN_W'(E_W);
  localparam logic [N-1:0]     ONE  = N'(1);

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_x;
  logic [E_W-1:0]   r_e;
  logic [LEN_W-1:0] r_len;
  logic [N-1:0]     r_m;
  logic [N-1:0]     r_r2;
  logic [N-1:0]     r_acc;
  logic [N-1:0]     r_xm;
  logic [LEN_W-1:0] r_k;
  logic [N-1:0]     r_result;

  logic [LEN_W-1:0] w_len_clip;
  logic             w_ebit;

  // Lengths beyond the exponent register are clipped; k never exceeds E_W-1,
  // so only the low index bits are needed for the bit select.
  assign w_len_clip = (in_e_len > EW_L) ? EW_L : in_e_len;
  assign w_ebit     = r_e[r_k[KW-1:0]];

  assign mont_m = r_m;
  assign result = r_result;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and output decode; operands are held through each WAIT state.
  always_comb begin
    w_next     = r_state;
    busy       = 1'b1;
    done       = 1'b0;
    mont_start = 1'b0;
    mont_a     = '0;
    mont_b     = '0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = TO_MONT;
      end
      TO_MONT: begin
        mont_start = 1'b1;
        mont_a     = r_x;
        mont_b     = r_r2;
        w_next     = WAIT_TO;
      end
      WAIT_TO: begin
        mont_a = r_x;
        mont_b = r_r2;
        if (mont_done) w_next = (r_len != '0) ? SQ : FROM;
      end
      SQ: begin
        mont_start = 1'b1;
        mont_a     = r_acc;
        mont_b     = r_acc;
        w_next     = WAIT_SQ;
      end
      WAIT_SQ: begin
        mont_a = r_acc;
        mont_b = r_acc;
        if (mont_done) w_next = w_ebit ? MUL : NEXT;
      end
      MUL: begin
        mont_start = 1'b1;
        mont_a     = r_acc;
        mont_b     = r_xm;
        w_next     = WAIT_MUL;
      end
      WAIT_MUL: begin
        mont_a = r_acc;
        mont_b = r_xm;
        if (mont_done) w_next = NEXT;
      end
      NEXT: begin
        w_next = (r_k == '0) ? FROM : SQ;
      end
      FROM: begin
        mont_start = 1'b1;
        mont_a     = r_acc;
        mont_b     = ONE;
        w_next     = WAIT_FROM;
      end
      WAIT_FROM: begin
        mont_a = r_acc;
        mont_b = ONE;
        if (mont_done) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b0;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  // Operand capture, accumulator/xm updates from products, and bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x      <= '0;
      r_e      <= '0;
      r_len    <= '0;
      r_m      <= '0;
      r_r2     <= '0;
      r_acc    <= '0;
      r_xm     <= '0;
      r_k      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x   <= in_x;
            r_e   <= in_e;
            r_len <= w_len_clip;
            r_m   <= in_m;
            r_r2  <= in_r2_mod_m;
            r_acc <= in_r_mod_m;
            r_k   <= w_len_clip - LEN_W'(1);
          end
        end
        WAIT_TO: begin
          if (mont_done) r_xm <= mont_result;
        end
        WAIT_SQ, WAIT_MUL: begin
          if (mont_done) r_acc <= mont_result;
        end
        NEXT: begin
          if (r_k != '0) r_k <= r_k - LEN_W'(1);
        end
        WAIT_FROM: begin
          if (mont_done) r_result <= mont_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl at a reduced 16-bit width with a behavioural
// Montgomery multiplier stub of fixed latency. Expected results are
// hand-computed constants.
module tb_rsa_modexp_ctrl;

  localparam int N      = 16;
  localparam int E_W    = 32;
  localparam int LEN_W  = 6;
  localparam int LAT    = 20;
  localparam int BUDGET = 4000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [N-1:0]     in_x = '0;
  logic [E_W-1:0]   in_e = '0;
  logic [LEN_W-1:0] in_e_len = '0;
  logic [N-1:0]     in_m = '0;
  logic [N-1:0]     in_r_mod_m = '0;
  logic [N-1:0]     in_r2_mod_m = '0;
  logic             busy;
  logic             done;
  logic [N-1:0]     result;
  logic             mont_start;
  logic [N-1:0]     mont_a;
  logic [N-1:0]     mont_b;
  logic [N-1:0]     mont_m;
  logic [N-1:0]     mont_result;
  logic             mont_done;

  rsa_modexp_ctrl #(.N(N), .E_W(E_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_e(in_e), .in_e_len(in_e_len), .in_m(in_m),
    .in_r_mod_m(in_r_mod_m), .in_r2_mod_m(in_r2_mod_m),
    .busy(busy), .done(done), .result(result),
    .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_result(mont_result), .mont_done(mont_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Multiplier stub state
  int         stubCnt = 0;
  logic       stubDone = 1'b0;
  logic [N-1:0] stubRes = '0;
  logic [N-1:0] latA = '0, latB = '0, latM = '0;
  int         unstable = 0;
  int         opCount = 0;
  int         pulseCount = 0;
  int         doneCount = 0;
  int         spurCount = 0;
  byte        opLog [0:255];
  logic       spurArm = 1'b0;
  logic       idleSpur = 1'b0;
  logic       spurHit;

  assign spurHit     = spurArm && mont_start && (mont_a == mont_b);
  assign mont_done   = stubDone | spurHit | idleSpur;
  assign mont_result = stubDone ? stubRes : 16'hBEEF;

  function automatic logic [N-1:0] montMul(input logic [N-1:0] a, b, m);
    logic [63:0] t;
    t = 64'(a) * 64'(b);
    for (int i = 0; i < N; i++) begin
      if (t[0]) t = t + 64'(m);
      t = t >> 1;
    end
    if (t >= 64'(m)) t = t - 64'(m);
    return t[N-1:0];
  endfunction

  function automatic byte classify(input logic [N-1:0] a, b);
    if (a == in_x && b == in_r2_mod_m) return "T";
    if (b == N'(1))                    return "F";
    if (a == b)                        return "S";
    return "M";
  endfunction

  // Behavioural multiplier with fixed latency, plus pulse/stability monitors.
  always @(posedge clk) begin
    if (mont_start) pulseCount <= pulseCount + 1;
    if (done)       doneCount  <= doneCount + 1;
    if (spurHit)    spurCount  <= spurCount + 1;
    stubDone <= 1'b0;
    if (stubCnt > 0) begin
      stubCnt <= stubCnt - 1;
      if (busy && (mont_a != latA || mont_b != latB || mont_m != latM))
        unstable <= unstable + 1;
      if (stubCnt == 1) begin
        stubDone <= 1'b1;
        stubRes  <= montMul(latA, latB, latM);
      end
    end else if (mont_start) begin
      latA    <= mont_a;
      latB    <= mont_b;
      latM    <= mont_m;
      stubCnt <= LAT;
      opLog[opCount[7:0]] <= classify(mont_a, mont_b);
      opCount <= opCount + 1;
    end
  end

  typedef struct {
    logic [N-1:0]     x;
    logic [E_W-1:0]   e;
    logic [LEN_W-1:0] len;
    logic [N-1:0]     m;
    logic [N-1:0]     expRes;
    int               expPulses;
    bit               chkTrace;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic loadInputs(input logic [N-1:0] x, input logic [E_W-1:0] e,
                            input logic [LEN_W-1:0] len, input logic [N-1:0] m);
    logic [63:0] rm;
    rm = 64'h10000 % 64'(m);
    in_x        = x;
    in_e        = e;
    in_e_len    = len;
    in_m        = m;
    in_r_mod_m  = rm[N-1:0];
    in_r2_mod_m = 16'((rm * rm) % 64'(m));
  endtask

  task automatic pulseStart();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({name, " done seen"}, 64'(seen), 64'd1);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    int p0, d0, o0;
    logic [55:0] tr;
    logic [55:0] expTr;
    loadInputs(v.x, v.e, v.len, v.m);
    p0 = pulseCount;
    d0 = doneCount;
    o0 = opCount;
    pulseStart();
    checkOutput({name, " busy after start"}, 64'(busy), 64'd1);
    waitDone(name);
    checkOutput({name, " result"}, 64'(result), 64'(v.expRes));
    checkOutput({name, " mont_start pulses"}, 64'(pulseCount - p0), 64'(v.expPulses));
    checkOutput({name, " done pulses"}, 64'(doneCount - d0), 64'd1);
    checkOutput({name, " busy idle"}, 64'(busy), 64'd0);
    if (v.chkTrace) begin
      tr = '0;
      for (int j = 0; j < 7; j++) tr = {tr[47:0], opLog[(o0 + j) % 256]};
      expTr = "TSMSSMF";
      checkOutput({name, " op trace"}, 64'(tr), 64'(expTr));
    end
  endtask

  initial begin
    int o0, p0, d0;
    logic reached;

    vecs[0] = '{16'd4,  32'd13,    6'd4,  16'd497,   16'd445, 9,  1'b0};
    vecs[1] = '{16'd3,  32'd5,     6'd3,  16'd7,     16'd5,   7,  1'b1};
    vecs[2] = '{16'd9,  32'd13,    6'd0,  16'd497,   16'd1,   2,  1'b0};
    vecs[3] = '{16'd2,  32'd65537, 6'd17, 16'd65521, 16'd30,  21, 1'b0};
    vecs[4] = '{16'd4,  32'd13,    6'd63, 16'd497,   16'd445, 37, 1'b0};
    vecs[5] = '{16'd5,  32'd0,     6'd4,  16'd11,    16'd1,   6,  1'b0};
    vecs[6] = '{16'd7,  32'd1,     6'd1,  16'd13,    16'd7,   4,  1'b0};
    vecs[7] = '{16'd10, 32'd255,   6'd8,  16'd101,   16'd91,  18, 1'b0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset outputs", 64'({busy, done, mont_start, result, mont_a, mont_b, mont_m}), 64'd0);
    reset = 1'b0;

    // stray mont_done while idle
    p0 = pulseCount;
    @(negedge clk) idleSpur = 1'b1;
    @(negedge clk) idleSpur = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle spurious done", 64'({busy, result, 16'(pulseCount - p0)}), 64'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // second start while busy plus spurious mont_done in SQ
    loadInputs(16'd4, 32'd13, 6'd4, 16'd497);
    p0 = pulseCount;
    d0 = doneCount;
    pulseStart();
    repeat (3) @(negedge clk);
    in_x  = 16'd3;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    in_x    = 16'd4;
    spurArm = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (spurHit) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk) spurArm = 1'b0;
    checkOutput("spur reached SQ", 64'(reached), 64'd1);
    waitDone("busy-start");
    checkOutput("busy-start result", 64'(result), 64'd445);
    checkOutput("busy-start pulses", 64'(pulseCount - p0), 64'd9);
    checkOutput("busy-start done pulses", 64'(doneCount - d0), 64'd1);
    checkOutput("spur injected once", 64'(spurCount), 64'd1);

    // reset while waiting on a square product
    loadInputs(16'd4, 32'd13, 6'd4, 16'd497);
    o0 = opCount;
    pulseStart();
    reached = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (opCount - o0 == 2) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("reached WAIT_SQ", 64'(reached), 64'd1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    checkOutput("mid-op reset outputs", 64'({busy, done, mont_start, result, mont_a, mont_b, mont_m}), 64'd0);
    p0 = pulseCount;
    repeat (40) @(negedge clk);
    checkOutput("stray done after reset", 64'({busy, result, 16'(pulseCount - p0)}), 64'd0);
    applyStimulus(vecs[0], "after-reset");

    checkOutput("operand stability", 64'(unstable), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
